stream_downsize: RTL and testbench
==================================

Name: stream_downsize

Overview:
- Width-converting stream stage: accepts one wide beat of T_DATA_RATIO lanes with per-lane keep and a last flag, and emits the kept lanes one per transfer on a narrow T_DATA_WIDTH valid/ready stream.
- Inverse companion of the packing upsizer; sits directly downstream of it on the wide side.
- Lanes are emitted in ascending lane index, unkept lanes are skipped, and packet boundaries are preserved via m_last_o.

Parameters:
- T_DATA_WIDTH, 1, width of one lane / narrow data word.
- T_DATA_RATIO, 2, number of lanes per wide beat; must be >= 2.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, asynchronous, active-low.
- s_data_i  input  T_DATA_WIDTH x [0:T_DATA_RATIO-1] (unpacked array)  wide beat lanes.
- s_keep_i  input  T_DATA_RATIO  lane valid mask; bit i qualifies lane i.
- s_last_i  input  1  wide beat closes a packet.
- s_valid_i  input  1  wide beat valid.
- s_ready_o  output  1  wide beat accepted when s_valid_i & s_ready_o.
- m_data_o  output  T_DATA_WIDTH  narrow data.
- m_last_o  output  1  final narrow word of packet.
- m_valid_o  output  1  narrow word valid.
- m_ready_i  input  1  downstream ready.

Behaviour:
- Reset (async, immediate): state IDLE, holding register and remaining-mask cleared, m_valid_o=0, m_last_o=0, m_data_o=0, s_ready_o=1.
- Storage: one holding register of T_DATA_RATIO lanes, a remaining-mask register rem[T_DATA_RATIO-1:0], and a held last flag.
- States: IDLE (nothing held), SEND (rem != 0).
- IDLE:
  - On accept with s_keep_i != 0: capture lanes, rem <= s_keep_i, latch last; go to SEND.
  - On accept with s_keep_i == 0: the beat is consumed and discarded, including its last flag; stay IDLE; no narrow output is produced.
- SEND:
  - cur = lowest set bit index of rem.
  - m_valid_o=1, m_data_o=lane[cur].
  - m_last_o = held_last & (rem has exactly one bit set).
  - On m_valid_o & m_ready_i: clear rem[cur].
- s_ready_o = (state==IDLE) | (state==SEND & rem one-hot & m_ready_i). The path from m_ready_i to s_ready_o is combinational. This is intentional, so back-to-back beats produce no bubble.
- Simultaneous final-lane handoff and new accept: the new beat loads directly and stays in SEND (or goes to IDLE if its keep is 0).
- Latency: a beat accepted at edge N presents its first kept lane in the cycle after edge N. Throughput is one narrow word per cycle with no idle cycles between consecutive beats.
- Stability: while m_valid_o=1 and m_ready_i=0, m_data_o and m_last_o hold stable and rem does not change.
- m_valid_o never drops without a handshake.
- The first-set-bit search is pure combinational priority logic over rem, with ascending index priority. The index width is max(1, $clog2(T_DATA_RATIO)).
- Non-contiguous keep (e.g. 0101) is legal; gaps are skipped with no dead cycles.
- Reset mid-operation discards the held beat and any unsent lanes; no partial output follows reset deassertion.
- Outputs in IDLE: m_valid_o=0, m_last_o=0; m_data_o is don't-care (drive lane 0 of the holding register).

Decomposition:
- Shared package stream_pkg holds the state enum (IDLE, SEND) and a lane-index-width helper function, clog2 clamped to a minimum of 1.
- One natural sub-module: lane_first_set. It is combinational, parameterised by T_DATA_RATIO, and has inputs mask and outputs idx, onehot_remaining (mask has exactly one bit), and any.

Test Plan (WIDTH=8, RATIO=4):
- Full beat: lanes {A0,A1,A2,A3}, keep=1111, last=1, m_ready=1 -> A0,A1,A2,A3 on 4 consecutive cycles; m_last only with A3; s_ready high only during the A3 cycle.
- Sparse keep: keep=0101, last=1, lanes {10,11,12,13} -> outputs 10 then 12 on consecutive cycles; m_last with 12; lanes 1 and 3 never appear.
- Backpressure: keep=1111, m_ready held low 3 cycles while lane 1 is presented -> m_data_o=A1 and m_valid_o stay stable; A2 follows the cycle after m_ready rises; no loss or duplication.
- Back-to-back: beat X (keep=1111, last=0) then beat Y (keep=0011, last=1) presented continuously -> 6 narrow words in 6 cycles; Y is accepted in the X3 cycle; m_last only on Y1.
- Zero keep: keep=0000, last=1 -> accepted in 1 cycle, no m_valid pulse, s_ready stays 1; a following beat is handled normally.
- Reset mid-beat: assert rst_n=0 after lane 1 is sent -> m_valid_o falls immediately; after release s_ready_o=1, m_valid_o=0, and no stale lanes are emitted.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared types and helpers for the stream width-conversion stages.
package stream_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Lane index width, never narrower than one bit.
  function automatic int lane_idx_w(input int ratio);
    return ($clog2(ratio) < 1) ? 1 : $clog2(ratio);
  endfunction

endpackage

// File: rtl/lane_first_set.sv
// Ascending-priority first-set-bit search over a lane mask, plus one-hot and any flags.
module lane_first_set
  import stream_pkg::*;
#(
  parameter int T_DATA_RATIO = 2,
  localparam int IDX_W = lane_idx_w(T_DATA_RATIO)
) (
  input  logic [T_DATA_RATIO-1:0] mask,
  output logic [IDX_W-1:0]        idx,
  output logic                    onehot_remaining,
  output logic                    any
);

  logic [T_DATA_RATIO-1:0] lower_s;

  // Walk downwards so the lowest set bit wins.
  always_comb begin
    idx = {IDX_W{1'b0}};
    for (int i = T_DATA_RATIO - 1; i >= 0; i--) begin
      idx = mask[i] ? IDX_W'(i) : idx;
    end
  end

  // Clearing the lowest set bit leaves zero exactly when one bit was set.
  assign lower_s          = mask & (mask - {{(T_DATA_RATIO-1){1'b0}}, 1'b1});
  assign any              = |mask;
  assign onehot_remaining = any & ~(|lower_s);

endmodule

// File: rtl/stream_downsize.sv
// Wide-to-narrow stream stage: emits the kept lanes of each wide beat one per
// narrow transfer in ascending lane order, carrying the packet last flag.
module stream_downsize
  import stream_pkg::*;
#(
  parameter int T_DATA_WIDTH = 1,
  parameter int T_DATA_RATIO = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [T_DATA_WIDTH-1:0] s_data_i [0:T_DATA_RATIO-1],
  input  logic [T_DATA_RATIO-1:0] s_keep_i,
  input  logic                    s_last_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o,
  output logic                    m_last_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i
);

  localparam int IDX_W = lane_idx_w(T_DATA_RATIO);

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [T_DATA_WIDTH-1:0] hold_r [0:T_DATA_RATIO-1];
  logic [T_DATA_RATIO-1:0] rem_r;
  logic [T_DATA_RATIO-1:0] rem_nxt_s;
  logic [T_DATA_RATIO-1:0] cur_bit_s;
  logic                    last_r;
  logic                    load_s;
  logic                    s_accept_s;
  logic                    m_fire_s;
  logic                    keep_any_s;
  logic [IDX_W-1:0]        cur_idx_s;
  logic                    rem_onehot_s;
  logic                    rem_any_s;

  lane_first_set #(
    .T_DATA_RATIO(T_DATA_RATIO)
  ) u_first_set (
    .mask             (rem_r),
    .idx              (cur_idx_s),
    .onehot_remaining (rem_onehot_s),
    .any              (rem_any_s)
  );

  // Decode the current lane index back to a single-bit clear mask.
  always_comb begin
    cur_bit_s = {T_DATA_RATIO{1'b0}};
    for (int i = 0; i < T_DATA_RATIO; i++) begin
      cur_bit_s[i] = (cur_idx_s == IDX_W'(i));
    end
  end

  // Ready is combinational on m_ready_i so the next beat loads with the final lane.
  assign s_ready_o  = (state_r == IDLE) | ((state_r == SEND) & rem_onehot_s & m_ready_i);
  assign s_accept_s = s_valid_i & s_ready_o;
  assign keep_any_s = (s_keep_i != {T_DATA_RATIO{1'b0}});
  assign m_valid_o  = (state_r == SEND) & rem_any_s;
  assign m_fire_s   = m_valid_o & m_ready_i;
  assign m_last_o   = m_valid_o & last_r & rem_onehot_s;
  assign m_data_o   = m_valid_o ? hold_r[cur_idx_s] : hold_r[0];

  // Next-state and remaining-mask update.
  always_comb begin
    state_nxt_s = state_r;
    rem_nxt_s   = rem_r;
    load_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (s_accept_s && keep_any_s) begin
          load_s      = 1'b1;
          rem_nxt_s   = s_keep_i;
          state_nxt_s = SEND;
        end else begin
          // A zero-keep beat is swallowed here along with its last flag.
          rem_nxt_s   = {T_DATA_RATIO{1'b0}};
          state_nxt_s = IDLE;
        end
      end
      SEND: begin
        if (m_fire_s) begin
          rem_nxt_s = rem_r & ~cur_bit_s;
        end else begin
          rem_nxt_s = rem_r;
        end
        if (s_accept_s && keep_any_s) begin
          load_s      = 1'b1;
          rem_nxt_s   = s_keep_i;
          state_nxt_s = SEND;
        end else if (s_accept_s || (m_fire_s && rem_onehot_s)) begin
          rem_nxt_s   = {T_DATA_RATIO{1'b0}};
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = SEND;
        end
      end
      default: begin
        rem_nxt_s   = {T_DATA_RATIO{1'b0}};
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      rem_r   <= {T_DATA_RATIO{1'b0}};
      last_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      rem_r   <= rem_nxt_s;
      if (load_s) begin
        last_r <= s_last_i;
      end
    end
  end

  // Lane holding register, captured only when a kept beat is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < T_DATA_RATIO; i++) begin
        hold_r[i] <= {T_DATA_WIDTH{1'b0}};
      end
    end else if (load_s) begin
      for (int i = 0; i < T_DATA_RATIO; i++) begin
        hold_r[i] <= s_data_i[i];
      end
    end
  end

endmodule

// File: tb/tb_stream_downsize.sv
// Directed bench for stream_downsize with WIDTH=8, RATIO=4.
module tb_stream_downsize;

  localparam int W = 8;
  localparam int R = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] s_data [0:R-1];
  logic [R-1:0] s_keep;
  logic         s_last;
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] m_data;
  logic         m_last;
  logic         m_valid;
  logic         m_ready;

  int checks;
  int failures;

  stream_downsize #(
    .T_DATA_WIDTH(W),
    .T_DATA_RATIO(R)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data_i  (s_data),
    .s_keep_i  (s_keep),
    .s_last_i  (s_last),
    .s_valid_i (s_valid),
    .s_ready_o (s_ready),
    .m_data_o  (m_data),
    .m_last_o  (m_last),
    .m_valid_o (m_valid),
    .m_ready_i (m_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic [W-1:0] base, input logic [R-1:0] keep, input logic last);
    for (int i = 0; i < R; i++) begin
      s_data[i] = base + W'(i);
    end
    s_keep  = keep;
    s_last  = last;
    s_valid = 1'b1;
  endtask

  // Check one narrow word mid-cycle.
  task automatic expect_word(input string tag, input logic [W-1:0] data, input logic last,
                             input logic rdy);
    @(negedge clk);
    check_eq({tag, "_valid"}, 32'(m_valid), 32'd1);
    check_eq({tag, "_data"},  32'(m_data),  32'(data));
    check_eq({tag, "_last"},  32'(m_last),  32'(last));
    check_eq({tag, "_srdy"},  32'(s_ready), 32'(rdy));
  endtask

  task automatic expect_idle(input string tag);
    @(negedge clk);
    check_eq({tag, "_valid"}, 32'(m_valid), 32'd0);
    check_eq({tag, "_srdy"},  32'(s_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    s_valid  = 1'b0;
    s_keep   = 4'b0000;
    s_last   = 1'b0;
    m_ready  = 1'b1;
    for (int i = 0; i < R; i++) s_data[i] = 8'h00;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_valid", 32'(m_valid), 32'd0);
    check_eq("rst_last",  32'(m_last),  32'd0);
    check_eq("rst_data",  32'(m_data),  32'd0);
    check_eq("rst_srdy",  32'(s_ready), 32'd1);
    rst_n = 1'b1;
    next_cyc();

    // Full beat
    drive_beat(8'hA0, 4'b1111, 1'b1);
    @(negedge clk);
    check_eq("full_acc_srdy", 32'(s_ready), 32'd1);
    next_cyc();
    s_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      expect_word("full", 8'hA0 + 8'(k), (k == 3), (k == 3));
      next_cyc();
    end
    expect_idle("full_end");

    // Sparse keep 0101
    drive_beat(8'd10, 4'b0101, 1'b1);
    next_cyc();
    s_valid = 1'b0;
    expect_word("sparse0", 8'd10, 1'b0, 1'b0);
    next_cyc();
    expect_word("sparse2", 8'd12, 1'b1, 1'b1);
    next_cyc();
    expect_idle("sparse_end");

    // Backpressure while lane 1 is presented
    drive_beat(8'hB0, 4'b1111, 1'b1);
    next_cyc();
    s_valid = 1'b0;
    expect_word("bp0", 8'hB0, 1'b0, 1'b0);
    next_cyc();
    m_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      expect_word("bp_hold", 8'hB1, 1'b0, 1'b0);
      next_cyc();
    end
    m_ready = 1'b1;
    expect_word("bp1", 8'hB1, 1'b0, 1'b0);
    next_cyc();
    expect_word("bp2", 8'hB2, 1'b0, 1'b0);
    next_cyc();
    expect_word("bp3", 8'hB3, 1'b1, 1'b1);
    next_cyc();
    expect_idle("bp_end");

    // Back-to-back X (1111, last=0) then Y (0011, last=1)
    drive_beat(8'hC0, 4'b1111, 1'b0);
    next_cyc();
    drive_beat(8'hD0, 4'b0011, 1'b1);
    for (int k = 0; k < 4; k++) begin
      expect_word("b2b_x", 8'hC0 + 8'(k), 1'b0, (k == 3));
      next_cyc();
    end
    s_valid = 1'b0;
    expect_word("b2b_y0", 8'hD0, 1'b0, 1'b0);
    next_cyc();
    expect_word("b2b_y1", 8'hD1, 1'b1, 1'b1);
    next_cyc();
    expect_idle("b2b_end");

    // Zero keep is swallowed, next beat unaffected
    drive_beat(8'hE0, 4'b0000, 1'b1);
    @(negedge clk);
    check_eq("zero_srdy", 32'(s_ready), 32'd1);
    next_cyc();
    s_valid = 1'b0;
    expect_idle("zero_after");
    drive_beat(8'hE0, 4'b0010, 1'b1);
    next_cyc();
    s_valid = 1'b0;
    expect_word("zero_next", 8'hE1, 1'b1, 1'b1);
    next_cyc();
    expect_idle("zero_end");

    // Reset after lane 1 is sent
    drive_beat(8'hF0, 4'b1111, 1'b1);
    next_cyc();
    s_valid = 1'b0;
    expect_word("rmid0", 8'hF0, 1'b0, 1'b0);
    next_cyc();
    expect_word("rmid1", 8'hF1, 1'b0, 1'b0);
    next_cyc();
    rst_n = 1'b0;
    #1;
    check_eq("rmid_async_valid", 32'(m_valid), 32'd0);
    check_eq("rmid_async_srdy",  32'(s_ready), 32'd1);
    next_cyc();
    @(negedge clk);
    rst_n = 1'b1;
    next_cyc();
    for (int k = 0; k < 4; k++) begin
      expect_idle("rmid_after");
      next_cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
